// File: rtl/store_commit_buffer.sv
// store_commit_buffer
// In-order FIFO of retired stores sitting between the ROB and data memory.
// Stores are encoded into lane-aligned word writes on entry, drained to memory
// one per accepted req/ack, and searched combinationally so younger loads can
// pick up data that has committed but not yet reached memory.

module store_commit_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     commit_we,
  input  logic [31:0]              commit_addr,
  input  logic [31:0]              commit_data,
  input  logic [2:0]               commit_funct3,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  input  logic                     mem_ack,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_addr,
  input  logic [2:0]               ld_funct3,
  output logic                     fwd_hit,
  output logic [31:0]              fwd_data,
  output logic                     fwd_conflict,
  output logic                     sb_full,
  output logic                     sb_empty,
  output logic [$clog2(DEPTH):0]   sb_count,
  output logic                     sb_overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    IDLE,
    REQ
  } drain_state_t;

  drain_state_t     state;
  logic [DEPTH-1:0] ent_valid;
  logic [29:0]      ent_waddr [DEPTH];
  logic [31:0]      ent_wdata [DEPTH];
  logic [3:0]       ent_be    [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             overflow_q;
  logic             push;
  logic             pop;
  logic             drop;

  // Byte-enable pattern for a given access size and byte offset; unknown sizes
  // yield an empty mask so such entries never take part in forwarding.
  function automatic logic [3:0] encode_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  encode_be = 4'b0001 << off;
      3'b001:  encode_be = off[1] ? 4'b1100 : 4'b0011;
      3'b010:  encode_be = 4'b1111;
      default: encode_be = 4'b0000;
    endcase
  endfunction

  // Replicate the low-aligned store value across every lane it could occupy.
  function automatic logic [31:0] encode_wdata(input logic [2:0] f3, input logic [31:0] data);
    case (f3)
      3'b000:  encode_wdata = {4{data[7:0]}};
      3'b001:  encode_wdata = {2{data[15:0]}};
      default: encode_wdata = data;
    endcase
  endfunction

  // A full buffer can still accept a commit in the same cycle the head drains.
  assign pop  = mem_req && mem_ack;
  assign push = commit_we && (!sb_full || pop);
  assign drop = commit_we && sb_full && !mem_ack;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Pointer, entry and drain-state update; push is written after pop so a full
  // buffer doing both keeps the newly written entry valid at the shared slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ent_valid  <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end
      if (push) begin
        ent_valid[tail] <= 1'b1;
        ent_waddr[tail] <= commit_addr[31:2];
        ent_wdata[tail] <= encode_wdata(commit_funct3, commit_data);
        ent_be[tail]    <= encode_be(commit_funct3, commit_addr[1:0]);
        tail            <= tail + 1'b1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
      count <= count_next;
      state <= (count_next != '0) ? REQ : IDLE;
    end
  end

  assign mem_req     = (state == REQ);
  assign mem_addr    = mem_req ? {ent_waddr[head], 2'b00} : 32'h0;
  assign mem_wdata   = mem_req ? ent_wdata[head] : 32'h0;
  assign mem_be      = mem_req ? ent_be[head] : 4'h0;
  assign sb_count    = count;
  assign sb_full     = (count == DEPTH[AW:0]);
  assign sb_empty    = (count == '0);
  assign sb_overflow = overflow_q;

  logic [3:0]    lb;
  logic          match_found;
  logic [3:0]    match_be;
  logic [31:0]   match_data;
  logic [AW-1:0] idx;
  logic          covered;

  // Walk entries oldest to youngest so the last match seen is the youngest.
  always_comb begin
    lb          = encode_be({1'b0, ld_funct3[1:0]}, ld_addr[1:0]);
    match_found = 1'b0;
    match_be    = 4'h0;
    match_data  = 32'h0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if (ent_valid[idx] && (ent_waddr[idx] == ld_addr[31:2]) && (ent_be[idx] != 4'h0)) begin
        match_found = 1'b1;
        match_be    = ent_be[idx];
        match_data  = ent_wdata[idx];
      end
    end
    covered      = ((match_be & lb) == lb);
    fwd_hit      = ld_valid && match_found && covered;
    fwd_conflict = ld_valid && match_found && !covered;
    fwd_data     = fwd_hit ? match_data : 32'h0;
  end

  logic unused_ld_sign;
  assign unused_ld_sign = ld_funct3[2];

endmodule

// File: doc/store_commit_buffer.md
# store_commit_buffer

Post-commit store buffer sitting directly downstream of the reorder buffer. It captures every retired store (address, data and funct3 as the ROB emits them at commit) into an in-order FIFO. It drains that FIFO to data memory over a req/ack handshake and answers same-cycle forwarding queries from the load unit so loads observe committed-but-undrained stores. Entries are architecturally committed and survive pipeline flushes and exceptions.

## Interface
- DEPTH, 8: number of entries, power of two, ≥2.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- commit_we  in  1  retired store valid (ROB out_MemWrite).
- commit_addr  in  32  store byte address (ROB out_Addr).
- commit_data  in  32  store source value, low-aligned (ROB out_value).
- commit_funct3  in  3  000 SB, 001 SH, 010 SW (ROB ROB_funct3).
- mem_req  out  1  head entry valid, request to memory.
- mem_addr  out  32  word address {head_addr[31:2],2'b00}.
- mem_wdata  out  32  lane-aligned write data.
- mem_be  out  4  byte enables.
- mem_ack  in  1  memory accepted head entry this cycle.
- ld_valid  in  1  forwarding query valid.
- ld_addr  in  32  load byte address.
- ld_funct3  in  3  load size (low two bits used; bit 2 = unsigned, ignored here).
- fwd_hit  out  1  youngest matching entry fully covers load bytes.
- fwd_data  out  32  that entry's lane-aligned word.
- fwd_conflict  out  1  matching entry exists but does not cover; load must retry.
- sb_full  out  1  count == DEPTH.
- sb_empty  out  1  count == 0.
- sb_count  out  $clog2(DEPTH)+1  occupancy.
- sb_overflow  out  1  sticky: a commit was dropped.

## Operation
- Storage: per entry {valid, word_addr[29:0], wdata[31:0], be[3:0]}; head/tail pointers $clog2(DEPTH) bits, wrap modulo DEPTH; separate count register.
- Encode on push (off = commit_addr[1:0]): SB: be = 4'b0001<<off, wdata = {4{data[7:0]}}; SH: be = off[1] ? 4'b1100 : 4'b0011, wdata = {2{data[15:0]}}; SW: be = 4'b1111, wdata = data. Other funct3 codes push with be = 0. These entries drain normally and never forward. Misalignment is not checked here; the ROB traps it before commit.
- Push: commit_we && (!sb_full || pop_this_cycle) writes entry at tail, tail+1. If commit_we && sb_full && !mem_ack: the commit is dropped and sb_overflow sets. sb_overflow stays set until rst.
- Pop: mem_req && mem_ack clears the head entry and advances head. A mem_ack with mem_req low is ignored.
- Count: +1 on push only, −1 on pop only, unchanged on push+pop.
- Drain has two states. IDLE while empty (mem_req=0). REQ while non-empty. mem_req/addr/wdata/be are driven from head registers and held stable until ack.
- Forwarding is combinational. The load mask lb is built from ld_funct3[1:0]/ld_addr[1:0] with the same encoding as stores. Scan valid entries from tail−1 toward head; the first entry with word_addr == ld_addr[31:2] and be ≠ 0 is the youngest match.
  - Youngest match with (be & lb) == lb: fwd_hit=1, fwd_data = its wdata.
  - Youngest match without full cover: fwd_conflict=1.
  - No match, or ld_valid=0: both 0, fwd_data=0.
- The forwarding scan sees only the registered state. A store being pushed this cycle is not visible. An entry being popped this cycle is still visible.

## Timing
- Reset (synchronous): head=tail=count=0, all valid=0, sb_overflow=0. mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0. fwd_hit=0, fwd_conflict=0, fwd_data=0. sb_empty=1, sb_full=0. rst mid-drain abandons the outstanding request; mem_req is low the cycle after.
- Push latency 1: commit at edge N, so mem_req and fwd visibility from cycle N+1.
- Back-to-back drain: ack at edge N with a remaining entry means the next entry is presented in cycle N+1 with mem_req still high; throughput is one store per cycle.
- Empty with push: mem_req rises the cycle after the push; no bypass from commit to memory.
- Full with simultaneous push and ack: both take effect and count stays DEPTH.
- Wrap: pointers roll DEPTH−1→0 without a bubble.

## Test plan
- SW 0x1000 ← 0xDEADBEEF, mem_ack tied 1 → next cycle mem_req=1, addr 0x1000, be 1111, wdata DEADBEEF; one cycle later sb_empty=1.
- SB 0x2003 ← 0x000000AB, SH 0x2002 ← 0x1234 → be 1000/wdata ABABABAB, then be 1100/wdata 12341234, in order.
- mem_ack held 0, 8 SW pushes → sb_full=1, count 8. A 9th push sets sb_overflow with count 8. A 10th push with mem_ack=1 that cycle is accepted; count stays 8 and sb_overflow stays 1.
- Buffered SW 0x3000=0x11223344, then SB 0x3001 ← 0x55. LW 0x3000 → fwd_conflict=1. LB 0x3001 → fwd_hit, fwd_data 55555555. LW 0x3004 → no hit, no conflict.
- Continuous push/ack of 20 stores with alternating mem_ack → all 20 appear in commit order across pointer wrap; none lost, none duplicated.
- rst asserted while mem_req=1 with 3 entries → next cycle mem_req=0, sb_empty=1, sb_overflow=0; a following push drains normally.
